// File: rtl/vmicro16_timer_apb.sv
// vmicro16_timer_apb: multi-channel APB down-counter timer.
// Each channel has a prescaler, periodic/one-shot mode, an interrupt enable
// and a write-1-to-clear pending flag.
`timescale 1ns/1ps

module vmicro16_timer_apb #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PRESCALE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  output logic [CHANNELS-1:0]   out,
  output logic                  irq
);

  localparam int unsigned CH_W = ADDR_WIDTH - 2;

  localparam logic [1:0] REG_LOAD     = 2'd0;
  localparam logic [1:0] REG_COUNT    = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_IE      = 2;
  localparam int unsigned CTRL_PEND    = 3;
  localparam int unsigned CTRL_RELOAD  = 4;

  // Per-channel state
  logic [DATA_WIDTH-1:0]     load_q  [CHANNELS];
  logic [DATA_WIDTH-1:0]     count_q [CHANNELS];
  logic [PRESCALE_WIDTH-1:0] pre_q   [CHANNELS];
  logic [PRESCALE_WIDTH-1:0] pcnt_q  [CHANNELS];
  logic [CHANNELS-1:0]       en_q;
  logic [CHANNELS-1:0]       oneshot_q;
  logic [CHANNELS-1:0]       ie_q;
  logic [CHANNELS-1:0]       pend_q;

  // Bus decode
  logic            apb_en;
  logic            apb_wr;
  logic [1:0]      reg_sel;
  logic [CH_W-1:0] ch_idx;

  logic [CHANNELS-1:0] ch_hit;
  logic [CHANNELS-1:0] wr_load;
  logic [CHANNELS-1:0] wr_count;
  logic [CHANNELS-1:0] wr_ctrl;
  logic [CHANNELS-1:0] wr_pre;
  logic [CHANNELS-1:0] reload;
  logic [CHANNELS-1:0] pre_wrap;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] expire;

  assign apb_en   = S_PSELx & S_PENABLE;
  assign apb_wr   = apb_en & S_PWRITE;
  assign reg_sel  = S_PADDR[1:0];
  assign ch_idx   = S_PADDR[ADDR_WIDTH-1:2];
  assign S_PREADY = apb_en;
  assign irq      = |(pend_q & ie_q);

  // Channel write strobes and tick/expiry qualification; a COUNT write or
  // RELOAD swallows a coincident tick so the written value is never decremented
  always_comb begin
    ch_hit   = '0;
    wr_load  = '0;
    wr_count = '0;
    wr_ctrl  = '0;
    wr_pre   = '0;
    reload   = '0;
    pre_wrap = '0;
    tick     = '0;
    expire   = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      ch_hit[i]   = (ch_idx == CH_W'(i));
      wr_load[i]  = apb_wr & ch_hit[i] & (reg_sel == REG_LOAD);
      wr_count[i] = apb_wr & ch_hit[i] & (reg_sel == REG_COUNT);
      wr_ctrl[i]  = apb_wr & ch_hit[i] & (reg_sel == REG_CTRL);
      wr_pre[i]   = apb_wr & ch_hit[i] & (reg_sel == REG_PRESCALE);
      reload[i]   = wr_ctrl[i] & S_PWDATA[CTRL_RELOAD];
      pre_wrap[i] = en_q[i] & (pcnt_q[i] == pre_q[i]);
      tick[i]     = pre_wrap[i] & ~(wr_count[i] | reload[i]);
      expire[i]   = tick[i] & (count_q[i] == '0);
    end
  end

  // Combinational read mux; unmapped channels and idle bus read 0
  always_comb begin
    S_PRDATA = '0;
    if (apb_en) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (ch_hit[i]) begin
          case (reg_sel)
            REG_LOAD:     S_PRDATA = load_q[i];
            REG_COUNT:    S_PRDATA = count_q[i];
            REG_CTRL:     S_PRDATA = DATA_WIDTH'({pend_q[i], ie_q[i], oneshot_q[i], en_q[i]});
            REG_PRESCALE: S_PRDATA = DATA_WIDTH'(pre_q[i]);
            default:      S_PRDATA = '0;
          endcase
        end
      end
    end
  end

  // Channel registers, prescalers, counters and expiry pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      en_q      <= '0;
      oneshot_q <= '0;
      ie_q      <= '0;
      pend_q    <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        load_q[i]  <= '0;
        count_q[i] <= '0;
        pre_q[i]   <= '0;
        pcnt_q[i]  <= '0;
      end
    end else begin
      out <= expire;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (wr_load[i]) load_q[i] <= S_PWDATA;

        // Prescaler: held at 0 while disabled, restarted by a PRESCALE write
        if (wr_pre[i]) begin
          pre_q[i]  <= S_PWDATA[PRESCALE_WIDTH-1:0];
          pcnt_q[i] <= '0;
        end else if (!en_q[i] || pre_wrap[i]) begin
          pcnt_q[i] <= '0;
        end else begin
          pcnt_q[i] <= pcnt_q[i] + PRESCALE_WIDTH'(1);
        end

        if (wr_count[i]) begin
          count_q[i] <= S_PWDATA;
        end else if (reload[i]) begin
          count_q[i] <= load_q[i];
        end else if (tick[i]) begin
          if (count_q[i] != '0)  count_q[i] <= count_q[i] - DATA_WIDTH'(1);
          else if (!oneshot_q[i]) count_q[i] <= load_q[i];
        end

        if (wr_ctrl[i]) begin
          en_q[i]      <= S_PWDATA[CTRL_EN];
          oneshot_q[i] <= S_PWDATA[CTRL_ONESHOT];
          ie_q[i]      <= S_PWDATA[CTRL_IE];
        end else if (expire[i] && oneshot_q[i]) begin
          en_q[i] <= 1'b0;
        end

        // Expiry set beats a same-cycle write-1-to-clear
        if (expire[i])                                pend_q[i] <= 1'b1;
        else if (wr_ctrl[i] && S_PWDATA[CTRL_PEND])   pend_q[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vmicro16_timer_apb.sv
// Directed testbench for vmicro16_timer_apb (4 channels, 16-bit data).
`timescale 1ns/1ps

module tb_vmicro16_timer_apb;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DW       = 16;
  localparam int unsigned PW       = 8;
  localparam int unsigned AW       = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic [CHANNELS-1:0] out;
  logic          irq;

  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] rd;

  vmicro16_timer_apb #(
    .CHANNELS(CHANNELS), .DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel), .S_PENABLE(penable),
    .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
    .out(out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Setup phase on one edge, commit on the following edge
  task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    step();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Zero-wait read sampled between edges
  task automatic apb_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
    #1;
    d = prdata;
    psel = 1'b0; penable = 1'b0;
    #1;
  endtask

  // Expected out vector for the all-channel run: channel i enabled at edge 2i
  // with COUNT=0 and LOAD=i, so it expires at edges 2i+1, 2i+1+(i+1), ...
  function automatic logic [CHANNELS-1:0] exp_all(input int e);
    logic [CHANNELS-1:0] v;
    v = '0;
    for (int i = 0; i < int'(CHANNELS); i++)
      if (e - 2*i - 1 >= 0 && ((e - 2*i - 1) % (i + 1)) == 0) v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    step(); step();
    check("rst_out",    32'(out),    32'h0);
    check("rst_irq",    32'(irq),    32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_prdata", 32'(prdata), 32'h0);
    reset = 1'b0;
    step();
    apb_read(6'd0, rd); check("rst_load0", 32'(rd), 32'h0);
    apb_read(6'd2, rd); check("rst_ctrl0", 32'(rd), 32'h0);

    // Periodic: ch0 LOAD=3, reload, EN|IE -> pulse every 4 clocks
    step();
    apb_write(6'd0, 16'd3);
    apb_write(6'd2, 16'h0010);
    apb_write(6'd3, 16'd0);
    apb_write(6'd2, 16'h0005);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("per_out", 32'(out), (k % 4 == 0) ? 32'h1 : 32'h0);
      check("per_irq", 32'(irq), (k >= 4) ? 32'h1 : 32'h0);
    end
    apb_write(6'd2, 16'h000D);
    check("per_w1c_irq", 32'(irq), 32'h0);
    step();
    check("per_w1c_out0", 32'(out), 32'h0);
    step();
    check("per_cont_out", 32'(out), 32'h1);
    check("per_cont_irq", 32'(irq), 32'h1);
    apb_write(6'd2, 16'h0008);
    check("per_off_irq", 32'(irq), 32'h0);

    // Prescale: ch1 LOAD=1, PRESCALE=4 -> period 10
    apb_write(6'd4, 16'd1);
    apb_write(6'd7, 16'd4);
    apb_write(6'd6, 16'h0001);
    for (int k = 1; k <= 25; k++) begin
      step();
      check("pre_out", 32'(out), (k >= 5 && (k - 5) % 10 == 0) ? 32'h2 : 32'h0);
      apb_read(6'd5, rd);
      check("pre_count", 32'(rd), (k >= 5 && (k - 5) % 10 < 5) ? 32'h1 : 32'h0);
    end
    apb_write(6'd6, 16'h0008);

    // One-shot: ch2 COUNT=2, EN|ONESHOT -> single pulse 3 clocks later
    apb_write(6'd9, 16'd2);
    apb_write(6'd10, 16'h0003);
    for (int k = 1; k <= 24; k++) begin
      step();
      check("os_out", 32'(out), (k == 3) ? 32'h4 : 32'h0);
      apb_read(6'd9, rd);
      check("os_count", 32'(rd), (k == 1) ? 32'h1 : 32'h0);
    end
    apb_read(6'd10, rd); check("os_ctrl", 32'(rd), 32'h000A);
    check("os_irq", 32'(irq), 32'h0);

    // Collision: W1C PEND on the expiry edge keeps PEND set
    step();
    apb_write(6'd1, 16'd2);
    apb_write(6'd2, 16'h0001);
    step();
    apb_write(6'd2, 16'h0009);
    check("col_w1c_out", 32'(out), 32'h1);
    apb_read(6'd2, rd); check("col_w1c_pend", 32'(rd), 32'h0009);
    apb_write(6'd2, 16'h0008);

    // Collision: COUNT write on a tick edge wins and suppresses the expiry
    step();
    apb_write(6'd2, 16'h0001);
    apb_write(6'd1, 16'd7);
    check("col_cnt_out", 32'(out), 32'h0);
    apb_read(6'd1, rd); check("col_cnt_7", 32'(rd), 32'h7);
    step();
    apb_read(6'd1, rd); check("col_cnt_6", 32'(rd), 32'h6);
    apb_read(6'd2, rd); check("col_cnt_nopend", 32'(rd), 32'h0001);
    apb_write(6'd2, 16'h0008);

    // Decode: channel index 4 and 15 are unmapped
    apb_write(6'd16, 16'h1234);
    apb_write(6'd17, 16'h0055);
    apb_write(6'd18, 16'h0007);
    apb_write(6'd19, 16'h00FF);
    apb_read(6'd16, rd); check("dec_rd_load4",  32'(rd), 32'h0);
    apb_read(6'd17, rd); check("dec_rd_count4", 32'(rd), 32'h0);
    step();
    apb_read(6'd60, rd); check("dec_rd_ch15", 32'(rd), 32'h0);
    apb_read(6'd0,  rd); check("dec_load0", 32'(rd), 32'h3);
    step();
    apb_read(6'd4,  rd); check("dec_load1", 32'(rd), 32'h1);
    apb_read(6'd8,  rd); check("dec_load2", 32'(rd), 32'h0);
    step();
    apb_read(6'd12, rd); check("dec_load3", 32'(rd), 32'h0);
    apb_read(6'd3,  rd); check("dec_pre0",  32'(rd), 32'h0);
    check("dec_irq", 32'(irq), 32'h0);
    check("dec_out", 32'(out), 32'h0);

    // Reset mid-count: ch3 LOAD=0xFFFF running, ch2 irq pending
    step();
    apb_write(6'd10, 16'h0004);
    check("rst_pre_irq", 32'(irq), 32'h1);
    apb_write(6'd12, 16'hFFFF);
    apb_write(6'd14, 16'h0010);
    apb_write(6'd14, 16'h0005);
    repeat (5) step();
    apb_read(6'd13, rd); check("rst_mid_count", 32'(rd), 32'hFFFA);
    reset = 1'b1;
    #1;
    check("rst_async_out", 32'(out), 32'h0);
    check("rst_async_irq", 32'(irq), 32'h0);
    apb_read(6'd12, rd); check("rst_load3",  32'(rd), 32'h0);
    apb_read(6'd13, rd); check("rst_count3", 32'(rd), 32'h0);
    apb_read(6'd14, rd); check("rst_ctrl3",  32'(rd), 32'h0);
    apb_read(6'd0,  rd); check("rst_load0b", 32'(rd), 32'h0);
    apb_read(6'd7,  rd); check("rst_pre1",   32'(rd), 32'h0);
    apb_read(6'd10, rd); check("rst_ctrl2",  32'(rd), 32'h0);
    step();
    reset = 1'b0;
    step();

    // All channels: LOAD=i, staggered enables, only ch3 has IE
    for (int i = 0; i < int'(CHANNELS); i++) apb_write(AW'(4 * i), DW'(i));
    apb_write(6'd2,  16'h0001);
    apb_write(6'd6,  16'h0001);
    apb_write(6'd10, 16'h0001);
    apb_write(6'd14, 16'h0005);
    check("all_out_e6", 32'(out), 32'(exp_all(6)));
    check("all_irq_e6", 32'(irq), 32'h0);
    for (int e = 7; e <= 22; e++) begin
      step();
      check("all_out", 32'(out), 32'(exp_all(e)));
      check("all_irq", 32'(irq), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
